// File: rtl/scv_bus_pkg.sv
// Address map, target/state enums and decode helper for the SCV system bus.
// SCV_BUS_WRAM_EN adds the internal work-RAM window at 0xFF80-0xFFFF.
package scv_bus_pkg;

  typedef enum logic [2:0] {TGT_ROM, TGT_VRAM, TGT_IO, TGT_WRAM, TGT_CART, TGT_NONE} e_bus_tgt;
  typedef enum logic [2:0] {IDLE, RD_LAT, RD_CAP, VRAM_WAIT, WR_ISSUE} e_bus_st;

  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam logic [15:0] ROM_LIM   = 16'h0FFF;
  localparam logic [15:0] VRAM_BASE = 16'h2000;
  localparam logic [15:0] VRAM_LIM  = 16'h3FFF;
  localparam logic [15:0] IO_BASE   = 16'h3400;
  localparam logic [15:0] IO_LIM    = 16'h340F;
  localparam logic [15:0] WRAM_BASE = 16'hFF80;
  localparam logic [15:0] WRAM_LIM  = 16'hFFFF;
  localparam logic [15:0] CART_BASE = 16'h8000;
  localparam logic [15:0] CART_LIM  = 16'hFFFF;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

  function automatic logic in_rng(input logic [15:0] a, input logic [15:0] b, input logic [15:0] l);
    return (a >= b) && (a <= l);
  endfunction

  // First match wins; IO sits inside the VRAM window and must be tested first.
  function automatic e_bus_tgt bus_decode(input logic [15:0] a);
    if (in_rng(a, ROM_BASE, ROM_LIM))   return TGT_ROM;
    if (in_rng(a, IO_BASE, IO_LIM))     return TGT_IO;
    if (in_rng(a, VRAM_BASE, VRAM_LIM)) return TGT_VRAM;
`ifdef SCV_BUS_WRAM_EN
    if (in_rng(a, WRAM_BASE, WRAM_LIM)) return TGT_WRAM;
`endif
    if (in_rng(a, CART_BASE, CART_LIM)) return TGT_CART;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/scv_wram.sv
// 128x8 single-port work RAM, registered read. Contents survive reset.
module scv_wram (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [6:0] i_a,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);
  logic [7:0] r_mem [0:127];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_a] <= i_d;
    o_q <= r_mem[i_a];
  end
endmodule

// File: rtl/scv_bus_ctrl.sv
// uPD7800 system bus controller: decode, read steering, posted writes, VRAM handshake.
// Define SCV_BUS_WRAM_EN to instantiate the internal 128-byte work RAM.
module scv_bus_ctrl
  import scv_bus_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CP1_POSEDGE,
  input  logic        CP2_NEGEDGE,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DB_O,
  input  logic        CPU_WRB,
  input  logic        CPU_M1,
  output logic [7:0]  CPU_DB_I,
  output logic [11:0] ROM_A,
  input  logic [7:0]  ROM_DB,
  output logic [12:0] VRAM_A,
  output logic [7:0]  VRAM_DB_O,
  output logic        VRAM_REQ,
  output logic        VRAM_WE,
  input  logic        VRAM_ACK,
  input  logic [7:0]  VRAM_DB_I,
  output logic [14:0] CART_A,
  input  logic [7:0]  CART_DB,
  output logic        CART_WR,
  output logic [3:0]  IO_A,
  output logic [7:0]  IO_DB_O,
  output logic        IO_WR,
  input  logic [7:0]  IO_DB_I,
  output logic [15:0] FETCH_CNT
);
  e_bus_st     r_st, w_nxt;
  e_bus_tgt    r_tgt, w_tgt;
  logic [14:0] r_addr;
  logic [15:0] r_pa, r_fcnt, w_a;
  logic [7:0]  r_wdata, r_pd, r_dbi, w_d, w_rd_q;
  logic        r_we, r_pend, r_pwrb, r_missed, late_ack;
  logic        w_busy_wr, w_use_pend, w_pend_set, w_start, w_wrb, w_cap, w_deadline;

  // Writes in flight are never aborted; a strobe landing on one is parked in r_pa/r_pd.
  assign w_busy_wr  = (r_st == WR_ISSUE) || ((r_st == VRAM_WAIT) && r_we);
  assign w_use_pend = (r_st == IDLE) && r_pend;
  assign w_pend_set = CP1_POSEDGE && (w_busy_wr || w_use_pend);
  assign w_start    = w_use_pend || (CP1_POSEDGE && !w_busy_wr);
  assign w_a        = w_use_pend ? r_pa   : CPU_A;
  assign w_d        = w_use_pend ? r_pd   : CPU_DB_O;
  assign w_wrb      = w_use_pend ? r_pwrb : CPU_WRB;
  assign w_tgt      = bus_decode(w_a);
  assign w_deadline = (r_st == VRAM_WAIT) && !r_we && CP2_NEGEDGE;

`ifdef SCV_BUS_WRAM_EN
  logic [7:0] w_wram_q;
  scv_wram u_wram (
    .i_clk (CLK),
    .i_we  ((r_st == WR_ISSUE) && (r_tgt == TGT_WRAM)),
    .i_a   (r_addr[6:0]),
    .i_d   (r_wdata),
    .o_q   (w_wram_q)
  );
`endif

  always_comb begin
    w_nxt  = r_st;
    w_cap  = 1'b0;
    w_rd_q = OPEN_BUS;
    case (r_st)
      RD_LAT: begin
        w_nxt = RD_CAP;
        if (r_tgt == TGT_IO) begin
          w_cap  = 1'b1;
          w_rd_q = IO_DB_I;
        end
      end
      RD_CAP: begin
        w_nxt = IDLE;
        w_cap = (r_tgt != TGT_IO);
        case (r_tgt)
          TGT_ROM:  w_rd_q = ROM_DB;
          TGT_CART: w_rd_q = CART_DB;
`ifdef SCV_BUS_WRAM_EN
          TGT_WRAM: w_rd_q = w_wram_q;
`endif
          default:  w_rd_q = OPEN_BUS;
        endcase
      end
      VRAM_WAIT: begin
        if (VRAM_ACK) begin
          w_nxt  = IDLE;
          w_cap  = !r_we && !CP2_NEGEDGE && !r_missed;
          w_rd_q = VRAM_DB_I;
        end
      end
      WR_ISSUE: w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
    // A new access preempts whatever read was pending.
    if (w_start) begin
      w_cap = 1'b0;
      if (w_tgt == TGT_VRAM) w_nxt = VRAM_WAIT;
      else if (w_wrb)        w_nxt = RD_LAT;
      else                   w_nxt = WR_ISSUE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_st     <= IDLE;
      r_tgt    <= TGT_NONE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_pend   <= 1'b0;
      r_pa     <= '0;
      r_pd     <= '0;
      r_pwrb   <= 1'b1;
      r_missed <= 1'b0;
      late_ack <= 1'b0;
      r_dbi    <= OPEN_BUS;
      r_fcnt   <= '0;
    end else begin
      r_st <= w_nxt;
      if (w_start) begin
        r_addr   <= w_a[14:0];
        r_wdata  <= w_d;
        r_we     <= !w_wrb;
        r_tgt    <= w_tgt;
        r_missed <= 1'b0;
      end else if (w_deadline) begin
        r_missed <= 1'b1;
      end
      if (w_deadline) late_ack <= 1'b1;
      if (w_pend_set) begin
        r_pend <= 1'b1;
        r_pa   <= CPU_A;
        r_pd   <= CPU_DB_O;
        r_pwrb <= CPU_WRB;
      end else if (w_use_pend) begin
        r_pend <= 1'b0;
      end
      if (w_cap) r_dbi <= w_rd_q;
      if (CP1_POSEDGE && CPU_M1) r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign CPU_DB_I  = r_dbi;
  assign FETCH_CNT = r_fcnt;
  assign ROM_A     = r_addr[11:0];
  assign VRAM_A    = r_addr[12:0];
  assign CART_A    = r_addr;
  assign IO_A      = r_addr[3:0];
  assign VRAM_DB_O = r_wdata;
  assign IO_DB_O   = r_wdata;
  assign VRAM_REQ  = (r_st == VRAM_WAIT) && !RESET;
  assign VRAM_WE   = VRAM_REQ && r_we;
  assign CART_WR   = (r_st == WR_ISSUE) && (r_tgt == TGT_CART);
  assign IO_WR     = (r_st == WR_ISSUE) && (r_tgt == TGT_IO);
endmodule

// File: tb/tb_scv_bus_ctrl.sv
// Directed bench for scv_bus_ctrl: read table plus hand sequences for VRAM, abort, post and reset.
module tb_scv_bus_ctrl;
  logic        clk = 1'b0, rst = 1'b1, cp1 = 1'b0, cp2 = 1'b0;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_dbo = '0;
  logic        cpu_wrb = 1'b1, cpu_m1 = 1'b0;
  logic [7:0]  cpu_dbi, rom_q, vram_dbo, cart_q, io_dbo, io_dbi;
  logic [7:0]  vram_dbi = '0;
  logic        vram_ack = 1'b0, vram_req, vram_we, cart_wr, io_wr;
  logic [11:0] rom_a;
  logic [12:0] vram_a;
  logic [14:0] cart_a;
  logic [3:0]  io_a;
  logic [15:0] fcnt;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  scv_bus_ctrl dut (
    .CLK(clk), .RESET(rst), .CP1_POSEDGE(cp1), .CP2_NEGEDGE(cp2),
    .CPU_A(cpu_a), .CPU_DB_O(cpu_dbo), .CPU_WRB(cpu_wrb), .CPU_M1(cpu_m1),
    .CPU_DB_I(cpu_dbi), .ROM_A(rom_a), .ROM_DB(rom_q),
    .VRAM_A(vram_a), .VRAM_DB_O(vram_dbo), .VRAM_REQ(vram_req), .VRAM_WE(vram_we),
    .VRAM_ACK(vram_ack), .VRAM_DB_I(vram_dbi),
    .CART_A(cart_a), .CART_DB(cart_q), .CART_WR(cart_wr),
    .IO_A(io_a), .IO_DB_O(io_dbo), .IO_WR(io_wr), .IO_DB_I(io_dbi),
    .FETCH_CNT(fcnt)
  );

  // External device models: synchronous ROM/cart, combinational IO.
  function automatic logic [7:0] rom_val(input logic [11:0] a);
    return (a == 12'h123) ? 8'h5A : (a[7:0] ^ 8'hA5);
  endfunction
  function automatic logic [7:0] cart_val(input logic [14:0] a);
    return a[7:0] + 8'h3C;
  endfunction
  always @(posedge clk) begin
    rom_q  <= rom_val(rom_a);
    cart_q <= cart_val(cart_a);
  end
  assign io_dbi = {4'hB, io_a};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] a, input logic wrb, input logic [7:0] d, input logic m1);
    cp1 = 1'b1; cpu_a = a; cpu_wrb = wrb; cpu_dbo = d; cpu_m1 = m1;
    tick();
    cp1 = 1'b0; cpu_wrb = 1'b1; cpu_m1 = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  exp;
    int          lat;
    int          kind;   // 0 ROM, 1 IO, 2 unmapped, 3 cart
  } vec_t;

  vec_t tbl[8];
  logic [7:0] prev;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0123, 8'h5A, 2, 0};
    tbl[1] = '{16'h0042, 8'hE7, 2, 0};
    tbl[2] = '{16'h3403, 8'hB3, 1, 1};
    tbl[3] = '{16'h340F, 8'hBF, 1, 1};
    tbl[4] = '{16'h1000, 8'hFF, 2, 2};
    tbl[5] = '{16'h8000, 8'h3C, 2, 3};
    tbl[6] = '{16'h4000, 8'hFF, 2, 2};
    tbl[7] = '{16'hABCD, 8'h09, 2, 3};

    tick(); tick();
    chk("rst_dbi", {24'h0, cpu_dbi}, 32'hFF);
    chk("rst_req", {31'h0, vram_req}, 32'h0);
    chk("rst_cartwr", {31'h0, cart_wr}, 32'h0);
    chk("rst_iowr", {31'h0, io_wr}, 32'h0);
    chk("rst_fcnt", {16'h0, fcnt}, 32'h0);
    chk("rst_addr", {rom_a, vram_a[3:0], cart_a[3:0], io_a, 8'h0}, 32'h0);
    chk("rst_late", {31'h0, dut.late_ack}, 32'h0);
    rst = 1'b0;
    tick();

    prev = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      strobe(tbl[i].a, 1'b1, 8'h00, 1'b0);
      if (tbl[i].kind == 0) chk($sformatf("rd%0d_rom_a", i), {20'h0, rom_a}, {20'h0, tbl[i].a[11:0]});
      if (tbl[i].kind == 1) chk($sformatf("rd%0d_io_a", i), {28'h0, io_a}, {28'h0, tbl[i].a[3:0]});
      if (tbl[i].kind == 3) chk($sformatf("rd%0d_cart_a", i), {17'h0, cart_a}, {17'h0, tbl[i].a[14:0]});
      tick();
      chk($sformatf("rd%0d_t1", i), {24'h0, cpu_dbi}, {24'h0, (tbl[i].lat == 1) ? tbl[i].exp : prev});
      tick();
      chk($sformatf("rd%0d_t2", i), {24'h0, cpu_dbi}, {24'h0, tbl[i].exp});
      tick();
      chk($sformatf("rd%0d_hold", i), {24'h0, cpu_dbi}, {24'h0, tbl[i].exp});
      prev = tbl[i].exp;
    end

    // VRAM write, ACK in the third request cycle
    strobe(16'h2010, 1'b0, 8'hC3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("vw_req%0d", c), {31'h0, vram_req}, 32'h1);
      chk($sformatf("vw_we%0d", c), {31'h0, vram_we}, 32'h1);
      chk($sformatf("vw_a%0d", c), {19'h0, vram_a}, 32'h0010);
      chk($sformatf("vw_d%0d", c), {24'h0, vram_dbo}, 32'hC3);
      if (c == 2) vram_ack = 1'b1;
      tick();
    end
    vram_ack = 1'b0;
    chk("vw_req_drop", {31'h0, vram_req}, 32'h0);
    tick();

    // VRAM read in time
    strobe(16'h2345, 1'b1, 8'h00, 1'b0);
    chk("vr_req", {31'h0, vram_req}, 32'h1);
    chk("vr_we", {31'h0, vram_we}, 32'h0);
    chk("vr_a", {19'h0, vram_a}, 32'h0345);
    tick();
    vram_ack = 1'b1; vram_dbi = 8'h99;
    tick();
    vram_ack = 1'b0;
    chk("vr_data", {24'h0, cpu_dbi}, 32'h99);
    chk("vr_req_drop", {31'h0, vram_req}, 32'h0);
    chk("vr_late0", {31'h0, dut.late_ack}, 32'h0);
    tick();

    // VRAM read with ACK after CP2 falling edge
    strobe(16'h2000, 1'b1, 8'h00, 1'b0);
    tick(); tick();
    cp2 = 1'b1;
    tick();
    cp2 = 1'b0;
    tick();
    chk("late_req_held", {31'h0, vram_req}, 32'h1);
    vram_ack = 1'b1; vram_dbi = 8'h77;
    tick();
    vram_ack = 1'b0;
    chk("late_data_hold", {24'h0, cpu_dbi}, 32'h99);
    chk("late_flag", {31'h0, dut.late_ack}, 32'h1);
    chk("late_req_drop", {31'h0, vram_req}, 32'h0);
    tick();

    // IO write, then unmapped read
    strobe(16'h3403, 1'b0, 8'h7E, 1'b0);
    chk("iow_pulse", {31'h0, io_wr}, 32'h1);
    chk("iow_a", {28'h0, io_a}, 32'h3);
    chk("iow_d", {24'h0, io_dbo}, 32'h7E);
    chk("iow_cart0", {31'h0, cart_wr}, 32'h0);
    tick();
    chk("iow_end", {31'h0, io_wr}, 32'h0);
    strobe(16'h1000, 1'b1, 8'h00, 1'b0);
    tick(); tick();
    chk("unmap_rd", {24'h0, cpu_dbi}, 32'hFF);
    chk("late_sticky", {31'h0, dut.late_ack}, 32'h1);

    // Top-page write: WRAM with the macro, cartridge otherwise
    strobe(16'hFF80, 1'b0, 8'h11, 1'b0);
`ifdef SCV_BUS_WRAM_EN
    chk("wram_w_cart0", {31'h0, cart_wr}, 32'h0);
    tick();
    chk("wram_w_cart1", {31'h0, cart_wr}, 32'h0);
    strobe(16'hFF80, 1'b1, 8'h00, 1'b0);
    chk("wram_r_cart0", {31'h0, cart_wr}, 32'h0);
    tick(); tick();
    chk("wram_rd", {24'h0, cpu_dbi}, 32'h11);
`else
    chk("cart_w_pulse", {31'h0, cart_wr}, 32'h1);
    chk("cart_w_a", {17'h0, cart_a}, 32'h7F80);
    chk("cart_w_io0", {31'h0, io_wr}, 32'h0);
    tick();
    chk("cart_w_end", {31'h0, cart_wr}, 32'h0);
    strobe(16'hFF80, 1'b1, 8'h00, 1'b0);
    tick(); tick();
    chk("cart_rd_top", {24'h0, cpu_dbi}, 32'hBC);
`endif
    tick();

    // ROM write is dropped
    strobe(16'h0123, 1'b0, 8'hAA, 1'b0);
    chk("romw_strobes", {29'h0, cart_wr, io_wr, vram_req}, 32'h0);
    tick(); tick();

    // Read aborted by a new strobe one cycle later
    strobe(16'h0123, 1'b1, 8'h00, 1'b0);
    strobe(16'h3405, 1'b1, 8'h00, 1'b0);
    tick();
    chk("abort_io", {24'h0, cpu_dbi}, 32'hB5);
    tick();
    chk("abort_hold", {24'h0, cpu_dbi}, 32'hB5);
    tick();

    // Strobe during a VRAM write is posted and serviced afterwards
    strobe(16'h2001, 1'b0, 8'h44, 1'b0);
    strobe(16'h3402, 1'b1, 8'h00, 1'b0);
    chk("post_req", {31'h0, vram_req}, 32'h1);
    chk("post_we", {31'h0, vram_we}, 32'h1);
    chk("post_vram_a", {19'h0, vram_a}, 32'h0001);
    vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    tick(); tick();
    chk("post_rd", {24'h0, cpu_dbi}, 32'hB2);
    tick();

    // Fetch counter, then reset during a pending VRAM request
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int k = 0; k < 3; k++) begin
      strobe(16'h0042, 1'b1, 8'h00, 1'b1);
      tick(); tick();
    end
    strobe(16'h0042, 1'b1, 8'h00, 1'b0);
    tick(); tick();
    chk("fcnt3", {16'h0, fcnt}, 32'h3);
    chk("fcnt_rd", {24'h0, cpu_dbi}, 32'hE7);
    strobe(16'h2000, 1'b1, 8'h00, 1'b1);
    chk("rst_pre_req", {31'h0, vram_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_req_same", {31'h0, vram_req}, 32'h0);
    tick();
    chk("rst_req_next", {31'h0, vram_req}, 32'h0);
    chk("rst_fcnt0", {16'h0, fcnt}, 32'h0);
    chk("rst_dbi_ff", {24'h0, cpu_dbi}, 32'hFF);
    rst = 1'b0;
    vram_ack = 1'b1; vram_dbi = 8'h55;
    tick();
    vram_ack = 1'b0;
    chk("stale_ack_req", {31'h0, vram_req}, 32'h0);
    tick();
    chk("stale_ack_dbi", {24'h0, cpu_dbi}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/scv_bus_ctrl.md
# scv_bus_ctrl

System bus controller sitting directly downstream of the uPD7800 core in the Super Cassette Vision top level. It decodes the CPU address bus, steers reads from BIOS ROM, internal work RAM, VRAM and cartridge back onto the CPU data input in time for the CPU's CP2 falling-edge sample, and posts CPU writes to the target devices. The VRAM port is shared with the video fetcher, so VRAM accesses use a request/acknowledge handshake.

## Interface
- No parameters; the address map is fixed in `scv_bus_pkg`.
- `CLK` in 1: system clock, the same clock as the CPU.
- `RESET` in 1: synchronous, active-high reset.
- `CP1_POSEDGE` in 1: CPU phase-1 rising strobe. This is the same strobe fed to the CPU.
- `CP2_NEGEDGE` in 1: CPU phase-2 falling strobe.
- `CPU_A` in 16: CPU address output.
- `CPU_DB_O` in 8: CPU write data.
- `CPU_WRB` in 1: CPU write strobe, active low.
- `CPU_M1` in 1: CPU opcode-fetch indicator. Used for the fetch counter only.
- `CPU_DB_I` out 8: read data to the CPU.
- `ROM_A` out 12: BIOS ROM address.
- `ROM_DB` in 8: BIOS ROM data, synchronous, 1-cycle latency.
- `VRAM_A` out 13: VRAM address.
- `VRAM_DB_O` out 8: VRAM write data.
- `VRAM_REQ` out 1: VRAM request.
- `VRAM_WE` out 1: VRAM write-not-read qualifier.
- `VRAM_ACK` in 1: VRAM grant and completion, 1-cycle pulse. Read data is valid in the same cycle.
- `VRAM_DB_I` in 8: VRAM read data.
- `CART_A` out 15: cartridge address.
- `CART_DB` in 8: cartridge data, synchronous, 1-cycle latency.
- `CART_WR` out 1: cartridge write strobe, 1 cycle.
- `IO_A` out 4: I/O register index.
- `IO_DB_O` out 8: I/O write data.
- `IO_WR` out 1: I/O write strobe, 1 cycle. Targets the sound/PPI block.
- `IO_DB_I` in 8: I/O read data, combinational.
- `FETCH_CNT` out 16: count of M1 cycles. Debug use only.

## Operation
- Address map, first match wins:
  - 0x0000–0x0FFF: ROM.
  - 0x2000–0x3FFF: VRAM.
  - 0x3400–0x340F: IO. Decoded ahead of VRAM.
  - 0xFF80–0xFFFF: WRAM (see Configuration).
  - 0x8000–0xFFFF: CART.
  - Everything else is unmapped. Unmapped reads return 0xFF; unmapped writes are dropped.
- Read path:
  - On every `CP1_POSEDGE` with `CPU_WRB`=1, the block latches `CPU_A`, decodes the target and starts a read.
  - ROM, CART and WRAM: data is captured 2 `CLK` after the strobe.
  - IO: data is captured 1 `CLK` after the strobe.
  - VRAM: `VRAM_REQ`=1, `VRAM_WE`=0 are held until `VRAM_ACK`; data is captured in the ACK cycle.
  - `CPU_DB_I` is a register. It updates only on capture and holds otherwise.
- Write path:
  - On `CP1_POSEDGE` with `CPU_WRB`=0 (the CPU asserts WRB at that edge), the block latches `CPU_A` and `CPU_DB_O` into a one-deep post buffer.
  - ROM writes are dropped.
  - CART, IO and WRAM: the strobe pulses 1 `CLK` later.
  - VRAM: `VRAM_REQ`=1, `VRAM_WE`=1 are held until `VRAM_ACK`.
- State machine, states `IDLE`, `RD_LAT`, `RD_CAP`, `VRAM_WAIT`, `WR_ISSUE`:
  - `IDLE` → `RD_LAT` on a read strobe to a non-VRAM target.
  - `RD_LAT` → `RD_CAP` → `IDLE`.
  - `IDLE` → `VRAM_WAIT` on a VRAM read or write strobe; `VRAM_WAIT` → `IDLE` on ACK.
  - `IDLE` → `WR_ISSUE` → `IDLE` on a non-VRAM write.
- Simultaneous events:
  - A new `CP1_POSEDGE` while the machine is not `IDLE` aborts a pending read. The new access takes priority.
  - A pending VRAM write is not aborted. It completes, and the new access is then serviced from `IDLE`.
- `FETCH_CNT`: increments by 1 on each `CP1_POSEDGE` with `CPU_M1`=1. Wraps from 0xFFFF to 0x0000.

## Timing
- Reset values:
  - `CPU_DB_I` = 0xFF.
  - All strobes and `VRAM_REQ` = 0.
  - `FETCH_CNT` = 0.
  - All address outputs = 0.
  - State = `IDLE`. The post buffer is emptied.
- Reset mid-operation: any VRAM request drops in the same cycle. An outstanding ACK arriving after reset is ignored.
- Deadline: read data must be in `CPU_DB_I` at least 1 `CLK` before the next `CP2_NEGEDGE`. The top level guarantees at least 4 `CLK` between `CP1_POSEDGE` and the following `CP2_NEGEDGE`.
- VRAM contention:
  - If the ACK misses the deadline, `CPU_DB_I` holds its previous value.
  - A sticky `late_ack` status bit is set; only `RESET` clears it. The bit is internal and is visible to the bench hierarchically.
- Write strobes are exactly 1 `CLK` wide, with address and data stable during the strobe.

## Configuration
- `SCV_BUS_WRAM_EN` defined:
  - A 128×8 WRAM is instantiated internally, decoded at 0xFF80–0xFFFF.
  - Reads are 2 `CLK`; writes complete in `WR_ISSUE`.
  - Contents are not cleared by reset.
- `SCV_BUS_WRAM_EN` undefined:
  - No RAM is instantiated, and the WRAM decode is removed.
  - 0xFF80–0xFFFF decodes to CART with CART timing.

## Structure
- `scv_bus_pkg` holds:
  - enum `e_bus_tgt` (`TGT_ROM`, `TGT_VRAM`, `TGT_IO`, `TGT_WRAM`, `TGT_CART`, `TGT_NONE`);
  - enum `e_bus_st` for the state machine;
  - base/limit constants for every region;
  - the open-bus value 0xFF.
- Sub-module `scv_wram`: 128×8 synchronous single-port RAM with a registered read. It is instantiated only under `SCV_BUS_WRAM_EN`.

## Test plan
- Read ROM: ROM holds 0x5A at 0x0123, CPU reads 0x0123 → `ROM_A`=0x123, and `CPU_DB_I`=0x5A 2 `CLK` after `CP1_POSEDGE`.
- VRAM write: CPU writes 0xC3 to 0x2010, with ACK after 3 `CLK` → `VRAM_REQ`, `VRAM_WE`=1, `VRAM_A`=0x0010, `VRAM_DB_O`=0xC3 held 3 `CLK`; `REQ` drops on ACK.
- Late VRAM ACK: CPU reads 0x2000 with ACK withheld past `CP2_NEGEDGE` → `CPU_DB_I` keeps its previous value and `late_ack`=1.
- IO write then unmapped read: write 0x7E to 0x3403 → `IO_WR` 1-cycle pulse with `IO_A`=3 and `IO_DB_O`=0x7E; a read of 0x1000 → `CPU_DB_I`=0xFF.
- WRAM: with the macro, write 0x11 to 0xFF80 then read it back → 0x11 with `CART_WR`=0 throughout. Without the macro, the same write → `CART_WR` pulse with `CART_A`=0x7F80.
- Reset/counter: 3 M1 fetches → `FETCH_CNT`=3; assert `RESET` during a pending VRAM request → `VRAM_REQ`=0 next cycle, `FETCH_CNT`=0, `CPU_DB_I`=0xFF.
